// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter.
// Holds the default widths, the read-owner encoding and the FSM state encoding.
package dmem_pkg;

  localparam int AW_DEF = 6;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_e;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_CPU_OWN    = 2'd1,
    ST_DBG_OWN    = 2'd2,
    ST_DBG_LOCKED = 2'd3
  } state_e;

endpackage

// File: rtl/dmem_arbiter_starve.sv
// Debug starvation counter: counts consecutive denied cycles of a request.
// Ports: clk, reset (sync, active-high), req, gnt in; at_limit out.
module starve_counter #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic gnt,
  output logic at_limit
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  assign at_limit = (cnt == CW'(LIMIT));

  // Cleared whenever the requester is served or stops asking;
  // otherwise counts up and saturates at LIMIT.
  always_ff @(posedge clk) begin
    if (reset || !req || gnt) begin
      cnt <= '0;
    end else if (!at_limit) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-port data memory between CPU Mem stage and debug.
// Ports: CPU req/we/addr/wdata -> gnt/stall/rvalid; debug req/we/addr/wdata/lock
// -> gnt/rvalid; memory we/addr/wdata out, mem_rdata in (1-cycle) -> rdata.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_stall,
  output logic          cpu_rvalid,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  input  logic          dbg_lock,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  state_e state, state_nx;
  owner_e rd_owner, rd_owner_nx;
  logic   at_limit;
  logic   lock_hold;

  starve_counter #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk     (CLOCK_50),
    .reset   (reset),
    .req     (dbg_req),
    .gnt     (dbg_gnt),
    .at_limit(at_limit)
  );

  assign lock_hold = (state == ST_DBG_LOCKED) && dbg_lock;

  // Grant priority: held lock, forced debug, CPU, debug.
  // Requests seen during reset are ignored.
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (reset) begin
      cpu_gnt = 1'b0;
    end else if (lock_hold) begin
      dbg_gnt = dbg_req;
    end else if (dbg_req && at_limit) begin
      dbg_gnt = 1'b1;
    end else if (cpu_req) begin
      cpu_gnt = 1'b1;
    end else if (dbg_req) begin
      dbg_gnt = 1'b1;
    end
  end

  always_comb begin
    state_nx    = ST_IDLE;
    rd_owner_nx = OWN_NONE;
    if (cpu_gnt) begin
      state_nx = ST_CPU_OWN;
    end else if (dbg_gnt) begin
      state_nx = dbg_lock ? ST_DBG_LOCKED : ST_DBG_OWN;
    end else if (lock_hold) begin
      state_nx = ST_DBG_LOCKED;
    end
    if (cpu_gnt && !cpu_we) begin
      rd_owner_nx = OWN_CPU;
    end else if (dbg_gnt && !dbg_we) begin
      rd_owner_nx = OWN_DBG;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state    <= ST_IDLE;
      rd_owner <= OWN_NONE;
    end else begin
      state    <= state_nx;
      rd_owner <= rd_owner_nx;
    end
  end

  assign cpu_stall  = cpu_req && !cpu_gnt && !reset;
  assign cpu_rvalid = (rd_owner == OWN_CPU) && !reset;
  assign dbg_rvalid = (rd_owner == OWN_DBG) && !reset;
  assign rdata      = mem_rdata;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dbg_gnt) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 64-word data memory between two requesters: the CPU pipeline's memory stage and a debug/loader port that preloads programs/data and dumps results.
- CPU normally has priority. A starvation counter forces a debug grant after a bounded wait.
- An optional debug lock holds the memory for bursts.
- Sits between the pipeline's Mem stage and the data memory; drives the pipeline stall line.

Parameters:
- AW, 6, word address width (memory depth 2**AW)
- DW, 32, data width
- STARVE_LIMIT, 4, consecutive cycles a pending debug request may be denied before a forced grant

Ports:
- CLOCK_50  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU memory access request (load or store), held until granted
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  AW  CPU word address
- cpu_wdata  in  DW  CPU store data
- cpu_gnt  out  1  CPU access issued to memory this cycle (combinational)
- cpu_stall  out  1  cpu_req & ~cpu_gnt; freezes the pipeline
- cpu_rvalid  out  1  CPU load data valid on rdata this cycle
- dbg_req  in  1  debug access request, held until granted
- dbg_we  in  1  debug write enable
- dbg_addr  in  AW  debug word address
- dbg_wdata  in  DW  debug write data
- dbg_lock  in  1  while 1 and owner is debug, CPU is never granted
- dbg_gnt  out  1  debug access issued this cycle (combinational)
- dbg_rvalid  out  1  debug read data valid on rdata this cycle
- rdata  out  DW  read data passthrough from mem_rdata
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, registered inside memory, valid 1 cycle after address

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE, starve_cnt = 0, rd_owner = NONE.
  - All outputs 0 during and immediately after reset, except rdata, which mirrors mem_rdata.
  - Requests present during reset are ignored.
- One access per cycle. A grant issues addr/we/wdata to memory in the same cycle.
- Read latency: exactly 1 cycle. rvalid is asserted the cycle after a granted load, to the owner recorded in rd_owner.
- Writes produce no rvalid.
- FSM states: IDLE, CPU_OWN, DBG_OWN, DBG_LOCKED. The state records the last grant.
  - Any state -> CPU_OWN on a CPU grant.
  - -> DBG_OWN on a debug grant with dbg_lock=0.
  - -> DBG_LOCKED on a debug grant with dbg_lock=1.
  - -> IDLE when there is no grant, except DBG_LOCKED, which holds while dbg_lock=1.
  - DBG_LOCKED -> IDLE when dbg_lock drops and there is no grant.
- Grant rules, evaluated in order:
  1. state = DBG_LOCKED and dbg_lock = 1: debug only; a cpu_req stalls.
  2. dbg_req and starve_cnt == STARVE_LIMIT: debug granted (forced).
  3. cpu_req: CPU granted.
  4. dbg_req: debug granted.
- starve_cnt:
  - Increments when dbg_req=1 and dbg_gnt=0.
  - Clears on dbg_gnt or when dbg_req=0.
  - Saturates at STARVE_LIMIT.
- Idle mux: when nothing is granted, mem_we = 0 and mem_addr/mem_wdata = 0.
- Simultaneous requests:
  - CPU wins unless rule 1 or 2 applies.
  - The loser's inputs must stay stable; the arbiter does not latch them.
- Back-to-back: a load granted in cycle N and any access in N+1 are both legal. rvalid(N+1) routes to the N owner regardless of the N+1 grant.
- Reset mid-operation: a pending rvalid is dropped (rd_owner cleared), the lock is released, and starve_cnt is cleared.
- Address wrap: addresses are AW bits wide; no range check.

Decomposition:
- Shared package dmem_pkg: AW/DW defaults, owner encoding (NONE=0, CPU=1, DBG=2), FSM state encoding.
- Starvation counter as sub-module starve_counter, with inputs req and gnt and output at_limit, parameter LIMIT.

Test Plan:
- Reset with cpu_req=dbg_req=1 held -> no grants, mem_we=0. First cycle after reset: cpu_gnt=1, dbg_gnt=0.
- Debug writes 0x11 to addr 0, 0x22 to addr 1 (CPU idle), then a debug read of addr 1 -> dbg_gnt each cycle; dbg_rvalid one cycle after the read with rdata=0x22; cpu_rvalid=0.
- CPU load every cycle with dbg_req held, STARVE_LIMIT=4 -> cpu_gnt for 4 cycles, then dbg_gnt forced on the 5th with cpu_stall=1, then CPU resumes; starve_cnt back to 0.
- dbg_lock=1, debug write to addr 2 granted, then cpu_req=1 (store 0x99 to addr 2) for 3 cycles -> cpu_stall=1 throughout. Lock drop -> CPU store granted next cycle; a later read of addr 2 returns 0x99.
- CPU load addr 0 in cycle N, debug load addr 1 in N+1 -> cpu_rvalid at N+1 (0x11), dbg_rvalid at N+2 (0x22).
- CPU load granted, then reset asserted the next cycle -> no cpu_rvalid, state IDLE, all grants 0.
